dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Data-memory access controller between the MEM pipeline stage and a single-port synchronous data RAM. It accepts one load/store request at a time and sequences the RAM port. Byte/halfword stores run as a two-cycle read-modify-write; loads return a sign- or zero-extended result. It raises a stall toward the pipeline while busy and flags misaligned accesses without touching the RAM.

## Interface
- DEPTH_LOG2, 12, RAM depth in 32-bit words; `ram_addr_o` width.
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  MEM stage presents an access.
- req_ready_o  out  1  controller can accept this cycle.
- ex_code_i  in  ExCode  one of LB/LH/LW/LBU/LHU/SB/SH/SW; any other code is accepted as a no-op.
- addr_i  in  MemAddrBus  byte address.
- wdata_i  in  MemBus  store data, low-justified.
- rd_waddr_i  in  RegAddrBus  load destination register.
- stall_o  out  1  = req_valid_i & ~req_ready_o.
- rsp_valid_o  out  1  one-cycle pulse: load result valid.
- rsp_rdata_o  out  RegBus  extended load result.
- rsp_waddr_o  out  RegAddrBus  destination of the returned load.
- misalign_o  out  1  one-cycle pulse: last accepted request was misaligned.
- ram_en_o / ram_we_o  out  1 / 1  RAM enable / write enable.
- ram_addr_o  out  DEPTH_LOG2  word address (addr[DEPTH_LOG2+1:2]).
- ram_wdata_o  out  MemBus  full word to write.
- ram_rdata_i  in  MemBus  read data, valid the cycle after a read-enable.

## Operation
- States: IDLE, LOAD_WAIT, RMW. Reset -> IDLE.
- A request is accepted when req_valid_i & req_ready_o. req_ready_o=1 only in IDLE.
- Alignment rules:
  - LH/LHU/SH require addr[0]=0.
  - LW/SW require addr[1:0]=0.
  - Byte accesses are always aligned.
  - Misaligned request: accepted, no RAM access, misalign_o=1 next cycle, stays IDLE.
- IDLE + aligned load: ram_en_o=1, ram_we_o=0 in the accept cycle. Capture ex_code, addr[1:0], rd_waddr. Go to LOAD_WAIT.
- LOAD_WAIT: extract the lane from ram_rdata_i using the captured index.
  - LB/LBU: byte at index; LB sign-extends, LBU zero-extends.
  - LH/LHU: index 0 -> bits 15:0, index 2 -> bits 31:16; LH sign-extends, LHU zero-extends.
  - LW: whole word.
  - Register the result into rsp_rdata_o / rsp_waddr_o with rsp_valid_o=1 for exactly the next cycle. Go to IDLE.
- IDLE + SW: ram_en_o=ram_we_o=1, ram_wdata_o=wdata_i in the accept cycle. Stay IDLE.
- IDLE + SB/SH: issue a read in the accept cycle. Capture the store data, index and word address. Go to RMW.
- RMW: ram_en_o=ram_we_o=1 at the captured address. ram_wdata_o = ram_rdata_i with the target byte/half replaced by wdata_i[7:0] / wdata_i[15:0]. Go to IDLE.
- No-op ex_code: accepted, no RAM access, no response, stays IDLE.
- RAM outputs are combinational from state and request; ram_en_o and ram_we_o are forced 0 while rst_n=0.

## Timing
- Load accepted at cycle T: RAM read at T, ready=0 at T+1, rsp_valid_o at T+2, next accept possible at T+2.
- SW: 1 cycle, write commits at the end of T. Back-to-back SW at full rate.
- SB/SH: 2 cycles; merged write commits at the end of T+1; next accept at T+2.
- A load accepted immediately after any store returns the newly written data; no forwarding is needed.
- misalign_o pulses at T+1; next accept possible at T+1.
- Reset values: state=IDLE, rsp_valid_o=0, rsp_rdata_o=0, rsp_waddr_o=0, misalign_o=0, req_ready_o=0 while in reset, all ram_* outputs=0.
- Reset asserted in LOAD_WAIT or RMW: the operation is abandoned, no response or write is issued, and the controller returns to IDLE.
- rsp_valid_o and a new accept may coincide in the same cycle.

## Structure
- type_pkg gains DmemState (IDLE/LOAD_WAIT/RMW).
- ExCode, MemBus, MemAddrBus, RegBus, RegAddrBus and MemIndex are reused from the existing packages.
- One combinational sub-module, dmem_lane_unit, performs both load extraction/extension and store merge, selected by ex_code and index.
- The top level holds the FSM, capture registers and RAM port drive.

## Test plan
- Preload word 0x8070_F081 at 0x100; LB at 0x100 -> 0xFFFF_FF81; LBU at 0x103 -> 0x0000_0080; LH at 0x102 -> 0xFFFF_8070; LHU at 0x100 -> 0x0000_F081; each rsp_valid_o exactly 2 cycles after accept.
- SB 0xAB at 0x101 over word 0x1122_3344 -> RAM holds 0x1122_AB44; stall_o high one cycle; a following LW returns 0x1122_AB44.
- SH 0xBEEF at 0x202 over 0x0000_0000 -> 0xBEEF_0000; then SW 0xDEAD_BEEF at 0x204 back-to-back with no stall.
- LW at 0x101 and SH at 0x203 -> misalign_o pulses, ram_en_o stays 0, memory unchanged, no rsp_valid_o.
- rst_n dropped during the RMW cycle of an SB -> no write occurs, outputs read 0, and after release an LW at the same address returns the original data.
- Random interleaved loads/stores with random req_valid_i gaps vs. a byte-array reference model -> every load result matches and stall_o = req_valid_i & ~req_ready_o on every cycle.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// Shared types for the data-memory access controller: bus widths, access codes
// and controller state, plus the alignment rule used when a request is accepted.
package dmem_ctrl_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] MemBus;
    typedef logic [XLEN-1:0] MemAddrBus;
    typedef logic [XLEN-1:0] RegBus;
    typedef logic [4:0]      RegAddrBus;
    typedef logic [1:0]      MemIndex;

    // Codes outside this list are legal on the bus and are treated as no-ops.
    typedef enum logic [3:0] {
        EX_NOP = 4'd0,
        EX_LB  = 4'd1,
        EX_LH  = 4'd2,
        EX_LW  = 4'd3,
        EX_LBU = 4'd4,
        EX_LHU = 4'd5,
        EX_SB  = 4'd6,
        EX_SH  = 4'd7,
        EX_SW  = 4'd8
    } ExCode;

    typedef enum logic [1:0] {
        DMEM_IDLE      = 2'd0,
        DMEM_LOAD_WAIT = 2'd1,
        DMEM_RMW       = 2'd2
    } DmemState;

    function automatic logic is_misaligned(input ExCode code, input MemIndex idx);
        logic mis;
        mis = 1'b0;
        case (code)
            EX_LH, EX_LHU, EX_SH: mis = idx[0];
            EX_LW, EX_SW:         mis = |idx;
            default:              mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Bundle of the MEM-stage request/response signals and the data RAM port seen
// by dmem_ctrl; slave is the controller side, master the pipeline/RAM side.
interface dmem_ctrl_if #(
    parameter int unsigned DEPTH_LOG2 = 12
);
    import dmem_ctrl_pkg::*;

    // Handshake: a request transfers on a rising edge where req_valid_i and
    // req_ready_o are both high; the request must stay stable while not ready.
    logic                  req_valid_i;
    logic                  req_ready_o;
    ExCode                 ex_code_i;
    MemAddrBus             addr_i;
    MemBus                 wdata_i;
    RegAddrBus             rd_waddr_i;
    logic                  stall_o;
    logic                  rsp_valid_o;
    RegBus                 rsp_rdata_o;
    RegAddrBus             rsp_waddr_o;
    logic                  misalign_o;
    logic                  ram_en_o;
    logic                  ram_we_o;
    logic [DEPTH_LOG2-1:0] ram_addr_o;
    MemBus                 ram_wdata_o;
    MemBus                 ram_rdata_i;
    DmemState              dbg_state_o;

    modport slave (
        input  req_valid_i, ex_code_i, addr_i, wdata_i, rd_waddr_i, ram_rdata_i,
        output req_ready_o, stall_o, rsp_valid_o, rsp_rdata_o, rsp_waddr_o,
               misalign_o, ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, dbg_state_o
    );

    modport master (
        output req_valid_i, ex_code_i, addr_i, wdata_i, rd_waddr_i, ram_rdata_i,
        input  req_ready_o, stall_o, rsp_valid_o, rsp_rdata_o, rsp_waddr_o,
               misalign_o, ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, dbg_state_o
    );

endinterface

// File: rtl/dmem_lane_unit.sv
// Combinational lane logic: extracts and extends load data from a RAM word, and
// merges byte/halfword store data into the word read back for read-modify-write.
module dmem_lane_unit
    import dmem_ctrl_pkg::*;
(
    input  ExCode       i_ex_code,
    input  MemIndex     i_index,
    input  MemBus       i_rdata,
    input  logic [15:0] i_wdata,
    output RegBus       o_load_data,
    output MemBus       o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_index)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_index[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_load_data = '0;
        case (i_ex_code)
            EX_LB:   o_load_data = {{24{w_byte[7]}}, w_byte};
            EX_LBU:  o_load_data = {24'h000000, w_byte};
            EX_LH:   o_load_data = {{16{w_half[15]}}, w_half};
            EX_LHU:  o_load_data = {16'h0000, w_half};
            EX_LW:   o_load_data = i_rdata;
            default: o_load_data = '0;
        endcase
    end

    // Halfword stores only ever reach here with index 0 or 2.
    always_comb begin
        o_merged = i_rdata;
        case (i_ex_code)
            EX_SB: begin
                case (i_index)
                    2'd0:    o_merged[7:0]   = i_wdata[7:0];
                    2'd1:    o_merged[15:8]  = i_wdata[7:0];
                    2'd2:    o_merged[23:16] = i_wdata[7:0];
                    default: o_merged[31:24] = i_wdata[7:0];
                endcase
            end
            EX_SH: begin
                if (i_index[1]) o_merged[31:16] = i_wdata;
                else            o_merged[15:0]  = i_wdata;
            end
            default: o_merged = i_rdata;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: one load/store at a time toward a single-port
// synchronous RAM, with RMW for sub-word stores and extended load results.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 12
) (
    input logic       clk,
    input logic       rst_n,
    dmem_ctrl_if.slave bus
);

    DmemState              r_state;
    DmemState              w_next;
    ExCode                 r_ex_code;
    MemIndex               r_index;
    RegAddrBus             r_rd_waddr;
    logic [15:0]           r_wdata;
    logic [DEPTH_LOG2-1:0] r_word_addr;
    logic                  r_rsp_valid;
    RegBus                 r_rsp_rdata;
    RegAddrBus             r_rsp_waddr;
    logic                  r_misalign;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_misalign;
    MemIndex               w_req_index;
    logic [DEPTH_LOG2-1:0] w_req_word_addr;
    logic                  w_en;
    logic                  w_we;
    logic [DEPTH_LOG2-1:0] w_addr;
    MemBus                 w_wdata;
    RegBus                 w_load_data;
    MemBus                 w_merged;
    logic                  w_unused_addr;

    assign w_ready         = rst_n & (r_state == DMEM_IDLE);
    assign w_accept        = bus.req_valid_i & w_ready;
    assign w_req_index     = bus.addr_i[1:0];
    assign w_req_word_addr = bus.addr_i[DEPTH_LOG2+1:2];
    assign w_misalign      = is_misaligned(bus.ex_code_i, w_req_index);
    assign w_unused_addr   = ^bus.addr_i[XLEN-1:DEPTH_LOG2+2];

    dmem_lane_unit u_lane (
        .i_ex_code   (r_ex_code),
        .i_index     (r_index),
        .i_rdata     (bus.ram_rdata_i),
        .i_wdata     (r_wdata),
        .o_load_data (w_load_data),
        .o_merged    (w_merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= DMEM_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_en    = 1'b0;
        w_we    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        case (r_state)
            DMEM_IDLE: begin
                if (w_accept && !w_misalign) begin
                    case (bus.ex_code_i)
                        EX_LB, EX_LH, EX_LW, EX_LBU, EX_LHU: begin
                            w_en   = 1'b1;
                            w_addr = w_req_word_addr;
                            w_next = DMEM_LOAD_WAIT;
                        end
                        EX_SW: begin
                            w_en    = 1'b1;
                            w_we    = 1'b1;
                            w_addr  = w_req_word_addr;
                            w_wdata = bus.wdata_i;
                        end
                        // Sub-word store: fetch the word now, write the merge next cycle.
                        EX_SB, EX_SH: begin
                            w_en   = 1'b1;
                            w_addr = w_req_word_addr;
                            w_next = DMEM_RMW;
                        end
                        default: w_next = DMEM_IDLE;
                    endcase
                end
            end
            DMEM_LOAD_WAIT: w_next = DMEM_IDLE;
            DMEM_RMW: begin
                w_en    = 1'b1;
                w_we    = 1'b1;
                w_addr  = r_word_addr;
                w_wdata = w_merged;
                w_next  = DMEM_IDLE;
            end
            default: w_next = DMEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_code   <= EX_NOP;
            r_index     <= '0;
            r_rd_waddr  <= '0;
            r_wdata     <= '0;
            r_word_addr <= '0;
        end else if (w_accept) begin
            r_ex_code   <= bus.ex_code_i;
            r_index     <= w_req_index;
            r_rd_waddr  <= bus.rd_waddr_i;
            r_wdata     <= bus.wdata_i[15:0];
            r_word_addr <= w_req_word_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_waddr <= '0;
            r_misalign  <= 1'b0;
        end else begin
            r_rsp_valid <= (r_state == DMEM_LOAD_WAIT);
            r_misalign  <= w_accept & w_misalign;
            if (r_state == DMEM_LOAD_WAIT) begin
                r_rsp_rdata <= w_load_data;
                r_rsp_waddr <= r_rd_waddr;
            end
        end
    end

    // The RAM port is held quiet during reset regardless of the request inputs.
    assign bus.ram_en_o    = rst_n & w_en;
    assign bus.ram_we_o    = rst_n & w_we;
    assign bus.ram_addr_o  = rst_n ? w_addr : '0;
    assign bus.ram_wdata_o = rst_n ? w_wdata : '0;

    assign bus.req_ready_o = w_ready;
    assign bus.stall_o     = bus.req_valid_i & ~w_ready;
    assign bus.rsp_valid_o = r_rsp_valid;
    assign bus.rsp_rdata_o = r_rsp_rdata;
    assign bus.rsp_waddr_o = r_rsp_waddr;
    assign bus.misalign_o  = r_misalign;
    assign bus.dbg_state_o = r_state;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: behavioural RAM, byte-array reference model
// and a cycle-exact response scoreboard.
module tb_dmem_ctrl;
    import dmem_ctrl_pkg::*;

    localparam int unsigned DL = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_ctrl_if #(.DEPTH_LOG2(DL)) bus ();

    dmem_ctrl #(.DEPTH_LOG2(DL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [31:0] mem   [0:(1<<DL)-1];
    logic [7:0]  ref_b [0:(4<<DL)-1];

    logic [36:0] exp_q[$];
    int          rsp_cyc_q[$];
    int          mis_cyc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous single-port RAM: read data appears the cycle after enable.
    always @(posedge clk) begin
        if (bus.ram_en_o) begin
            bus.ram_rdata_i <= mem[bus.ram_addr_o];
            if (bus.ram_we_o) mem[bus.ram_addr_o] = bus.ram_wdata_o;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic tb_misaligned(input ExCode code, input logic [1:0] a);
        case (code)
            EX_LH, EX_LHU, EX_SH: return a[0] != 1'b0;
            EX_LW, EX_SW:         return a != 2'b00;
            default:              return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [13:0] b;
        b = {a[13:2], 2'b00};
        return {ref_b[b+3], ref_b[b+2], ref_b[b+1], ref_b[b]};
    endfunction

    function automatic logic [31:0] model_load(input ExCode code, input logic [31:0] a);
        logic [13:0] b;
        logic [7:0]  by;
        logic [15:0] h;
        b  = a[13:0];
        by = ref_b[b];
        h  = {ref_b[b+1], ref_b[b]};
        case (code)
            EX_LB:   return {{24{by[7]}}, by};
            EX_LBU:  return {24'h0, by};
            EX_LH:   return {{16{h[15]}}, h};
            EX_LHU:  return {16'h0, h};
            default: return ref_word(a);
        endcase
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        logic [13:0] b;
        b = {a[13:2], 2'b00};
        mem[a[13:2]] = w;
        ref_b[b] = w[7:0];
        ref_b[b+1] = w[15:8];
        ref_b[b+2] = w[23:16];
        ref_b[b+3] = w[31:24];
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.req_valid_i = 1'b0;
        end
    endtask

    task automatic issue(input ExCode code, input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] rd, output int waits);
        logic        mis;
        logic        is_ld;
        logic        is_st;
        logic [13:0] b;
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.ex_code_i   = code;
        bus.addr_i      = a;
        bus.wdata_i     = wd;
        bus.rd_waddr_i  = rd;
        #1;
        waits = 0;
        while (bus.req_ready_o !== 1'b1 && waits < 10) begin
            @(negedge clk);
            #1;
            waits++;
        end
        chk("accept_ready", {31'b0, bus.req_ready_o}, 32'd1);
        mis   = tb_misaligned(code, a[1:0]);
        is_ld = (code == EX_LB || code == EX_LH || code == EX_LW || code == EX_LBU || code == EX_LHU);
        is_st = (code == EX_SB || code == EX_SH || code == EX_SW);
        chk("ram_en", {31'b0, bus.ram_en_o}, {31'b0, !mis && (is_ld || is_st)});
        chk("ram_we", {31'b0, bus.ram_we_o}, {31'b0, !mis && code == EX_SW});
        if (!mis && (is_ld || is_st)) chk("ram_addr", {20'b0, bus.ram_addr_o}, {20'b0, a[13:2]});
        if (!mis && code == EX_SW) chk("ram_wdata", bus.ram_wdata_o, wd);
        b = a[13:0];
        if (mis) mis_cyc_q.push_back(cyc + 1);
        else if (is_ld) begin
            exp_q.push_back({rd, model_load(code, a)});
            rsp_cyc_q.push_back(cyc + 2);
        end else if (code == EX_SB) ref_b[b] = wd[7:0];
        else if (code == EX_SH) begin
            ref_b[b] = wd[7:0];
            ref_b[b+1] = wd[15:8];
        end else if (code == EX_SW) begin
            ref_b[b] = wd[7:0];
            ref_b[b+1] = wd[15:8];
            ref_b[b+2] = wd[23:16];
            ref_b[b+3] = wd[31:24];
        end
        @(posedge clk);
        #1;
    endtask

    // Per-cycle monitor: stall relation, cycle-exact responses and misalign pulses.
    always @(negedge clk) begin
        logic        exp_v;
        logic        exp_m;
        logic [36:0] e;
        #2;
        chk("stall", {31'b0, bus.stall_o}, {31'b0, bus.req_valid_i & ~bus.req_ready_o});
        exp_v = (rsp_cyc_q.size() > 0) && (rsp_cyc_q[0] == cyc);
        chk("rsp_valid", {31'b0, bus.rsp_valid_o}, {31'b0, exp_v});
        if (exp_v) begin
            void'(rsp_cyc_q.pop_front());
            e = exp_q.pop_front();
            chk("rsp_rdata", bus.rsp_rdata_o, e[31:0]);
            chk("rsp_waddr", {27'b0, bus.rsp_waddr_o}, {27'b0, e[36:32]});
        end
        exp_m = (mis_cyc_q.size() > 0) && (mis_cyc_q[0] == cyc);
        if (exp_m) void'(mis_cyc_q.pop_front());
        chk("misalign", {31'b0, bus.misalign_o}, {31'b0, exp_m});
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [7:0] saved [0:3];
        for (int i = 0; i < (1 << DL); i++) mem[i] = 32'h0;
        for (int i = 0; i < (4 << DL); i++) ref_b[i] = 8'h0;
        for (int i = 0; i < 64; i++) preload(i * 4, $urandom);

        // Reset with a store presented: nothing may reach the RAM.
        bus.req_valid_i = 1'b1;
        bus.ex_code_i   = EX_SW;
        bus.addr_i      = 32'h0000_0410;
        bus.wdata_i     = 32'hCAFE_F00D;
        bus.rd_waddr_i  = 5'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", {31'b0, bus.req_ready_o}, 32'd0);
        chk("rst_rsp_valid", {31'b0, bus.rsp_valid_o}, 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata_o, 32'd0);
        chk("rst_rsp_waddr", {27'b0, bus.rsp_waddr_o}, 32'd0);
        chk("rst_misalign", {31'b0, bus.misalign_o}, 32'd0);
        chk("rst_ram_en", {31'b0, bus.ram_en_o}, 32'd0);
        chk("rst_ram_we", {31'b0, bus.ram_we_o}, 32'd0);
        chk("rst_ram_addr", {20'b0, bus.ram_addr_o}, 32'd0);
        chk("rst_ram_wdata", bus.ram_wdata_o, 32'd0);
        chk("rst_state", {30'b0, bus.dbg_state_o}, {30'b0, DMEM_IDLE});
        bus.req_valid_i = 1'b0;
        rst_n = 1'b1;
        idle(2);
        chk("rst_no_write", mem[32'h410 >> 2], 32'h0);

        // Load extraction/extension, issued back-to-back.
        preload(32'h100, 32'h8070_F081);
        issue(EX_LB,  32'h100, 32'h0, 5'd1, w);
        issue(EX_LBU, 32'h103, 32'h0, 5'd2, w);
        chk("load_back_to_back_wait", w, 32'd1);
        issue(EX_LH,  32'h102, 32'h0, 5'd3, w);
        issue(EX_LHU, 32'h100, 32'h0, 5'd4, w);
        idle(3);

        // Byte RMW followed immediately by a load of the same word.
        preload(32'h400, 32'h1122_3344);
        issue(EX_SB, 32'h401, 32'h0000_00AB, 5'd0, w);
        issue(EX_LW, 32'h400, 32'h0, 5'd5, w);
        chk("sb_stall_cycles", w, 32'd1);
        idle(3);
        chk("sb_mem", mem[32'h400 >> 2], 32'h1122_AB44);

        // Halfword RMW, then full-rate word stores.
        preload(32'h200, 32'h0);
        issue(EX_SH, 32'h202, 32'h0000_BEEF, 5'd0, w);
        idle(1);
        issue(EX_SW, 32'h204, 32'hDEAD_BEEF, 5'd0, w);
        chk("sw_first_wait", w, 32'd0);
        issue(EX_SW, 32'h208, 32'h1234_5678, 5'd0, w);
        chk("sw_back_to_back_wait", w, 32'd0);
        idle(2);
        chk("sh_mem", mem[32'h200 >> 2], 32'hBEEF_0000);
        chk("sw_mem0", mem[32'h204 >> 2], 32'hDEAD_BEEF);
        chk("sw_mem1", mem[32'h208 >> 2], 32'h1234_5678);

        // Misaligned accesses: pulse, no RAM traffic, next accept right away.
        issue(EX_LW, 32'h101, 32'h0, 5'd6, w);
        issue(EX_SH, 32'h203, 32'h0000_5555, 5'd0, w);
        chk("misalign_next_accept_wait", w, 32'd0);
        issue(ExCode'(4'hF), 32'h200, 32'hFFFF_FFFF, 5'd7, w);
        idle(3);
        chk("misalign_mem_lw", mem[32'h100 >> 2], 32'h8070_F081);
        chk("misalign_mem_sh", mem[32'h200 >> 2], 32'hBEEF_0000);

        // Reset during the RMW write cycle abandons the store.
        preload(32'h300, 32'h5566_7788);
        for (int i = 0; i < 4; i++) saved[i] = ref_b[32'h300 + i];
        issue(EX_SB, 32'h302, 32'h0000_0099, 5'd0, w);
        bus.req_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rmw_rst_state", {30'b0, bus.dbg_state_o}, {30'b0, DMEM_IDLE});
        chk("rmw_rst_ram_en", {31'b0, bus.ram_en_o}, 32'd0);
        chk("rmw_rst_ram_we", {31'b0, bus.ram_we_o}, 32'd0);
        chk("rmw_rst_ram_wdata", bus.ram_wdata_o, 32'd0);
        chk("rmw_rst_rsp_rdata", bus.rsp_rdata_o, 32'd0);
        chk("rmw_rst_ready", {31'b0, bus.req_ready_o}, 32'd0);
        for (int i = 0; i < 4; i++) ref_b[32'h300 + i] = saved[i];
        idle(2);
        rst_n = 1'b1;
        idle(1);
        chk("rmw_rst_mem", mem[32'h300 >> 2], 32'h5566_7788);
        issue(EX_LW, 32'h300, 32'h0, 5'd8, w);
        idle(3);

        // Random interleaved traffic against the reference model.
        for (int n = 0; n < 120; n++) begin
            ExCode c;
            case ($urandom_range(0, 8))
                0: c = EX_LB;
                1: c = EX_LH;
                2: c = EX_LW;
                3: c = EX_LBU;
                4: c = EX_LHU;
                5: c = EX_SB;
                6: c = EX_SH;
                7: c = EX_SW;
                default: c = ExCode'(4'hE);
            endcase
            issue(c, 32'($urandom_range(0, 255)), $urandom, 5'($urandom_range(1, 31)), w);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
        end
        idle(5);
        for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_word(i * 4));
        chk("rsp_queue_empty", exp_q.size(), 32'd0);
        chk("misalign_queue_empty", mis_cyc_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
